// File: rtl/sync_fifo_pkg.sv
// ============================================================================
// Module      : fifo_pkg
// Description : Shared types, mode constants and sizing helper for sync_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  typedef struct packed {
    logic full;
    logic almost_full;
    logic empty;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  function automatic int level_bits(input int size);
    return $clog2(size) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo_if.sv
// ============================================================================
// Module      : sync_fifo_if
// Description : Write/read/status bundle between sync_fifo and its neighbours.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sync_fifo_if
  import fifo_pkg::*;
#(
  parameter int BITS       = 32,
  parameter int LEVEL_BITS = level_bits(16)
);

  logic                  p_write_en;
  logic [BITS-1:0]       p_write_data;
  logic                  p_write_full;
  logic                  p_write_almost_full;
  logic                  p_read_en;
  logic [BITS-1:0]       p_read_data;
  logic                  p_read_empty;
  logic                  p_read_almost_empty;
  logic [LEVEL_BITS-1:0] p_level;
  logic                  p_overflow;
  logic                  p_underflow;
  logic                  p_err_clear;

  modport master (
    output p_write_en, p_write_data, p_read_en, p_err_clear,
    input  p_write_full, p_write_almost_full, p_read_data, p_read_empty,
    input  p_read_almost_empty, p_level, p_overflow, p_underflow
  );

  modport slave (
    input  p_write_en, p_write_data, p_read_en, p_err_clear,
    output p_write_full, p_write_almost_full, p_read_data, p_read_empty,
    output p_read_almost_empty, p_level, p_overflow, p_underflow
  );

endinterface

`default_nettype wire

// File: rtl/sync_fifo_mem.sv
// ============================================================================
// Module      : sync_fifo_mem
// Description : SIZE x BITS storage, synchronous write, asynchronous read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_mem #(
  parameter int BITS = 32,
  parameter int SIZE = 16
) (
  input  logic                    clk,
  input  logic                    i_we,
  input  logic [$clog2(SIZE)-1:0] i_waddr,
  input  logic [BITS-1:0]         i_wdata,
  input  logic [$clog2(SIZE)-1:0] i_raddr,
  output logic [BITS-1:0]         o_rdata
);

  logic [BITS-1:0] r_mem [SIZE];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with level, threshold flags, sticky errors
//               and optional first-word-fall-through read mode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo
  import fifo_pkg::*;
#(
  parameter int BITS            = 32,
  parameter int SIZE            = 16,
  parameter int FWFT            = FIFO_MODE_STD,
  parameter int ALMOST_FULL_TH  = SIZE - 2,
  parameter int ALMOST_EMPTY_TH = 2,
  parameter int LEVEL_BITS      = level_bits(SIZE)
) (
  input  logic       clk,
  input  logic       rst,
  sync_fifo_if.slave bus
);

  localparam int c_ADDR_BITS = $clog2(SIZE);
  localparam int c_PTR_BITS  = c_ADDR_BITS + 1;

  localparam logic [LEVEL_BITS-1:0] c_LEVEL_FULL = LEVEL_BITS'(SIZE);
  localparam logic [LEVEL_BITS-1:0] c_AF_TH      = LEVEL_BITS'(ALMOST_FULL_TH);
  localparam logic [LEVEL_BITS-1:0] c_AE_TH      = LEVEL_BITS'(ALMOST_EMPTY_TH);

  localparam fifo_status_t c_STAT_RST = '{
    full:         1'b0,
    almost_full:  (ALMOST_FULL_TH <= 0),
    empty:        1'b1,
    almost_empty: 1'b1,
    overflow:     1'b0,
    underflow:    1'b0
  };

  logic [c_PTR_BITS-1:0] r_wr_ptr;
  logic [c_PTR_BITS-1:0] r_rd_ptr;
  logic [LEVEL_BITS-1:0] r_level;
  logic [LEVEL_BITS-1:0] w_level_nxt;
  fifo_status_t          r_stat;
  fifo_status_t          w_stat_nxt;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [BITS-1:0]       w_mem_rdata;
  logic                  w_unused_ptr_msbs;

  assign w_wr_acc = bus.p_write_en && !r_stat.full;
  assign w_rd_acc = bus.p_read_en  && !r_stat.empty;

  // Pointer MSBs only carry the wrap lap; storage uses the low bits.
  assign w_unused_ptr_msbs = r_wr_ptr[c_PTR_BITS-1] ^ r_rd_ptr[c_PTR_BITS-1];

  always_comb begin
    w_level_nxt = r_level;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_level_nxt = r_level + 1'b1;
      2'b01:   w_level_nxt = r_level - 1'b1;
      default: w_level_nxt = r_level;
    endcase

    w_stat_nxt              = r_stat;
    w_stat_nxt.full         = (w_level_nxt == c_LEVEL_FULL);
    w_stat_nxt.empty        = (w_level_nxt == '0);
    w_stat_nxt.almost_full  = (w_level_nxt >= c_AF_TH);
    w_stat_nxt.almost_empty = (w_level_nxt <= c_AE_TH);
    // A fresh error in the clearing cycle keeps the flag set.
    w_stat_nxt.overflow     = (bus.p_write_en && r_stat.full) ||
                              (r_stat.overflow && !bus.p_err_clear);
    w_stat_nxt.underflow    = (bus.p_read_en && r_stat.empty) ||
                              (r_stat.underflow && !bus.p_err_clear);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_stat   <= c_STAT_RST;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_level <= w_level_nxt;
      r_stat  <= w_stat_nxt;
    end
  end

  sync_fifo_mem #(
    .BITS (BITS),
    .SIZE (SIZE)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr[c_ADDR_BITS-1:0]),
    .i_wdata (bus.p_write_data),
    .i_raddr (r_rd_ptr[c_ADDR_BITS-1:0]),
    .o_rdata (w_mem_rdata)
  );

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      // Holds the last popped entry so the output is stable while empty.
      logic [BITS-1:0] r_hold;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_hold <= '0;
        end else if (w_rd_acc) begin
          r_hold <= w_mem_rdata;
        end
      end

      assign bus.p_read_data = r_stat.empty ? r_hold : w_mem_rdata;
    end else begin : g_std
      logic [BITS-1:0] r_rd_data;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_rd_data <= '0;
        end else if (w_rd_acc) begin
          r_rd_data <= w_mem_rdata;
        end
      end

      assign bus.p_read_data = r_rd_data;
    end
  endgenerate

  assign bus.p_write_full        = r_stat.full;
  assign bus.p_write_almost_full = r_stat.almost_full;
  assign bus.p_read_empty        = r_stat.empty;
  assign bus.p_read_almost_empty = r_stat.almost_empty;
  assign bus.p_overflow          = r_stat.overflow;
  assign bus.p_underflow         = r_stat.underflow;
  assign bus.p_level             = r_level;

endmodule

`default_nettype wire
